// File: rtl/reaction_autoresponder.sv
// Self-test player for the reaction-timer game: waits for the stimulus, holds off a
// programmed number of millisecond ticks, then emulates an active-low key press.
module reaction_autoresponder #(
  parameter int TICK_DIV = 50000,
  parameter int PRESS_MS = 20,
  parameter int MAX_MS   = 9999
) (
  input  logic        MAX10_CLK1_50,
  input  logic        reset,
  input  logic        enable,
  input  logic        stim,
  input  logic [13:0] delay_ms,
  output logic        key_n,
  output logic        busy,
  output logic        done,
  output logic        missed,
  output logic [13:0] elapsed_ms
);

  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HOLD_W = (PRESS_MS > 1) ? $clog2(PRESS_MS + 1) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(PRESS_MS - 1);
  localparam logic [13:0]       MAX_LAT   = 14'(MAX_MS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_DELAY,
    S_PRESS,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [2:0]        sync_reg;
  logic [2:0]        sync_next;
  logic [PRE_W-1:0]  pre_reg, pre_next;
  logic [HOLD_W-1:0] hold_reg, hold_next;
  logic [13:0]       lat_reg, lat_next;
  logic [13:0]       cnt_reg, cnt_next;
  logic [13:0]       elapsed_reg, elapsed_next;
  logic              key_n_reg, key_n_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              missed_reg, missed_next;

  logic        s2, s3, rise, fall, tick;
  logic        timed_next, entering;
  logic [13:0] cnt_inc;
  logic [13:0] lat_clamped;

  // Stage 0/1 resynchronize the asynchronous stimulus; stage 2 is the edge reference.
  assign sync_next = {sync_reg[1:0], stim};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
          sync_reg[gi] <= 1'b0;
        end else begin
          sync_reg[gi] <= sync_next[gi];
        end
      end
    end
  endgenerate

  assign s2          = sync_reg[1];
  assign s3          = sync_reg[2];
  assign rise        = s2 & ~s3;
  assign fall        = ~s2 & s3;
  assign tick        = (pre_reg == PRE_LAST);
  assign cnt_inc     = cnt_reg + 14'd1;
  assign lat_clamped = (delay_ms > MAX_LAT) ? MAX_LAT : delay_ms;

  always_comb begin
    state_next = state_reg;
    if (!enable) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:  state_next = S_ARM;
        S_ARM:   if (!s2) state_next = S_WAIT;
        S_WAIT:  if (rise) state_next = S_DELAY;
        S_DELAY: begin
          // A dropped stimulus takes priority over a press that would start this cycle.
          if (fall) begin
            state_next = S_ARM;
          end else if ((lat_reg == 14'd0) || (tick && (cnt_inc == lat_reg))) begin
            state_next = S_PRESS;
          end
        end
        S_PRESS: if (tick && (hold_reg == HOLD_LAST)) state_next = S_DONE;
        S_DONE:  state_next = S_ARM;
        default: state_next = S_IDLE;
      endcase
    end

    timed_next = (state_next == S_DELAY) || (state_next == S_PRESS);
    entering   = timed_next && (state_next != state_reg);

    pre_next = '0;
    if (timed_next && !entering) begin
      pre_next = tick ? '0 : pre_reg + 1'b1;
    end

    lat_next = lat_reg;
    cnt_next = cnt_reg;
    if ((state_reg == S_WAIT) && (state_next == S_DELAY)) begin
      lat_next = lat_clamped;
      cnt_next = '0;
    end else if ((state_reg == S_DELAY) && tick && (lat_reg != 14'd0)) begin
      cnt_next = cnt_inc;
    end

    elapsed_next = elapsed_reg;
    if ((state_reg == S_DELAY) && (state_next == S_PRESS)) begin
      elapsed_next = cnt_next;
    end

    hold_next = '0;
    if ((state_reg == S_PRESS) && (state_next == S_PRESS)) begin
      hold_next = tick ? hold_reg + 1'b1 : hold_reg;
    end

    key_n_next  = (state_next != S_PRESS);
    busy_next   = timed_next;
    done_next   = (state_next == S_DONE);
    missed_next = (state_reg == S_DELAY) && (state_next == S_ARM);
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      pre_reg     <= '0;
      hold_reg    <= '0;
      lat_reg     <= '0;
      cnt_reg     <= '0;
      elapsed_reg <= '0;
      key_n_reg   <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      missed_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pre_reg     <= pre_next;
      hold_reg    <= hold_next;
      lat_reg     <= lat_next;
      cnt_reg     <= cnt_next;
      elapsed_reg <= elapsed_next;
      key_n_reg   <= key_n_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      missed_reg  <= missed_next;
    end
  end

  assign key_n      = key_n_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign missed     = missed_reg;
  assign elapsed_ms = elapsed_reg;

endmodule

// File: doc/reaction_autoresponder.md
# reaction_autoresponder

Automatic player for the reaction-timer game, used in board self-test. It watches the stimulus the game drives onto LEDR, waits a programmed latency, then emulates a KEY press with an active-low pulse. The top level muxes this pulse onto the game's response key when self-test is enabled. It also reports the latency it actually produced, so the game's measured score can be checked against a known value.

## Interface
Parameters:
- TICK_DIV, 50000: clock cycles per millisecond tick (50 MHz → 1 ms); use a small value in simulation.
- PRESS_MS, 20: emulated key hold time, in ticks.
- MAX_MS, 9999: clamp for `delay_ms`; matches the four-digit display.

Ports:
- MAX10_CLK1_50  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  self-test on; low forces IDLE.
- stim  in  1  stimulus, OR of LEDR[9:0]; asynchronous, synchronized internally.
- delay_ms  in  14  programmed response latency in ms; sampled on entering DELAY.
- key_n  out  1  emulated key, active low; idle 1.
- busy  out  1  high in DELAY and PRESS.
- done  out  1  one-cycle pulse after a completed press.
- missed  out  1  one-cycle pulse when stimulus drops before the press.
- elapsed_ms  out  14  ticks counted in the last DELAY; binary.

## Operation
- **Synchronizer:** `stim` → two flops (s1, s2) → edge register s3. `rise = s2 & ~s3`, `fall = ~s2 & s3`.
- **Prescaler:** counts 0..TICK_DIV-1. `tick` is asserted when the count equals TICK_DIV-1, then the count wraps to 0. The prescaler is cleared to 0 on every DELAY and PRESS entry.
- **Latency latch:** on DELAY entry, `lat = min(delay_ms, MAX_MS)`. The tick counter `cnt` is cleared to 0.
- **State machine:**
  - IDLE: if `enable`, go to ARM.
  - ARM: wait for synced stim (s2) = 0, so a stimulus already lit at enable is ignored. Then go to WAIT.
  - WAIT: on `rise`, go to DELAY.
  - DELAY:
    - If `lat == 0`, go to PRESS on the first DELAY cycle.
    - Otherwise `cnt` increments on each `tick`. When `cnt` reaches `lat`, go to PRESS.
    - If `fall` occurs before that, pulse `missed` and go to ARM. No press is made.
    - `fall` and "cnt reaches lat" in the same cycle: `missed` wins.
  - PRESS:
    - `key_n` = 0. `elapsed_ms` = `cnt`, captured on PRESS entry.
    - Hold for PRESS_MS ticks, then set `key_n` = 1 and go to DONE.
    - Stimulus falling during PRESS is ignored; the press always completes.
  - DONE: pulse `done` for one cycle, then go to ARM.
- `enable` low in any state: next state is IDLE, and `key_n` returns to 1 on the next cycle. `done` and `missed` do not pulse. `elapsed_ms` holds its value.
- `reset`: every register returns to its reset value on the next edge, overriding everything, including mid-PRESS.
- `cnt` is 14 bits and cannot exceed MAX_MS, so it never wraps.

## Timing
- **Reset values:** state IDLE, `key_n` 1, `busy` 0, `done` 0, `missed` 0, `elapsed_ms` 0, s1/s2/s3 0, prescaler 0, `cnt` 0.
- **Stimulus path:** `stim` sampled high at edge n → s2 high at n+1 → `rise` asserted in cycle n+1 → DELAY entered at edge n+2.
- **Press onset:** `key_n` falls `lat`·TICK_DIV cycles after DELAY entry, ±0. With `lat` = 0 it falls one cycle after DELAY entry.
- **Press width:** `key_n` is low for exactly PRESS_MS·TICK_DIV cycles.
- **Completion:** `done` is high in the cycle immediately after `key_n` returns high.
- **Outputs:** all outputs are registered. `busy` is asserted on the same edge as DELAY entry.
- **Re-arm:** the next stimulus is accepted only after s2 has been observed low in ARM, which takes at least 1 cycle.

## Test plan
Simulation settings for all scenarios: TICK_DIV=4, PRESS_MS=2.
1. Reset, then `enable`=1, `delay_ms`=5, stim rises → `key_n` low 20 cycles after DELAY entry, for 8 cycles; `done` pulses once; `elapsed_ms`=5.
2. `delay_ms`=0 → `key_n` low one cycle after DELAY entry; `elapsed_ms`=0; `missed` never asserted.
3. `delay_ms`=16383 → clamped to 9999; `elapsed_ms`=9999; press begins 39996 cycles after DELAY entry.
4. `delay_ms`=10, stim falls after 3 ticks → one `missed` pulse, `key_n` stays 1, FSM in ARM; a new rise is then serviced normally.
5. Stim already high when `enable` rises → no press until stim goes low and rises again; stim dropping during PRESS → full 8-cycle press and `done` still occur.
6. `reset` (or `enable`=0) asserted mid-PRESS → `key_n`=1 and `busy`=0 the next cycle, no `done` pulse. After reset `elapsed_ms`=0; after `enable`=0 it holds its value.
